dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 4 KB byte-addressed data memory. It shares the single DM port between the CPU MEM stage (requester 0) and the program loader/debug port (requester 1). It registers the winning command, drives the DM for exactly one cycle, captures read data, and returns a one-cycle acknowledge to the winner. It also rejects misaligned or illegal byte-enable writes before they reach the memory.

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dm_align_chk.sv | 36 +++
 rtl/dm_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dm_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
//   Shared definitions for the data-memory access path.
//   - DM_ADDR_W / DM_DATA_W : default byte-address and data widths of the DM
//   - BE_BYTE / BE_HALF / BE_WORD : DM byte-enable encodings (access size)
//   - dm_state_e : arbiter/sequencer FSM state encoding
// ---------------------------------------------------------------------------
package dm_pkg;

  localparam int DM_ADDR_W = 12;
  localparam int DM_DATA_W = 32;

  // The DM encodes the access size, not a lane mask: the data always sits in
  // the low bits of the write bus and the DM places it at the byte address.
  localparam logic [3:0] BE_BYTE = 4'b1000;
  localparam logic [3:0] BE_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_align_chk.sv
// ---------------------------------------------------------------------------
// dm_align_chk
//   Combinational legality check for one DM access.
//   An access is rejected when
//     - it is a write whose byte enable is not one of the DM size encodings,
//     - it is a halfword access on an odd address,
//     - it is a word access on an address that is not a multiple of four.
//   Reads go through the same alignment rule; their byte enable is otherwise
//   not policed.
//
//   Ports
//     addr_lo_i [1:0] : low two bits of the byte address
//     be_i      [3:0] : byte enable (DM size encoding)
//     we_i            : 1 = write, 0 = read
//     err_o           : 1 = access must not reach the memory
// ---------------------------------------------------------------------------
module dm_align_chk
  import dm_pkg::*;
(
  input  logic [1:0] addr_lo_i,
  input  logic [3:0] be_i,
  input  logic       we_i,
  output logic       err_o
);

  logic legal_be;
  logic half_misalign;
  logic word_misalign;

  assign legal_be      = (be_i == BE_BYTE) || (be_i == BE_HALF) || (be_i == BE_WORD);
  assign half_misalign = (be_i == BE_HALF) && addr_lo_i[0];
  assign word_misalign = (be_i == BE_WORD) && (addr_lo_i != 2'b00);

  assign err_o = half_misalign || word_misalign || (we_i && !legal_be);

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//   Two-port arbiter and access sequencer for the byte-addressed data memory.
//   Requester 0 is the CPU MEM stage, requester 1 the loader/debug port.
//   A request seen in IDLE is latched into a command register, the DM is
//   driven from that register for exactly one cycle (ACC), and the winner
//   receives a one-cycle acknowledge (RSP) together with its error flag.
//   Illegal or misaligned accesses are latched with an error flag and never
//   raise the DM write strobe.
//
//   Build option
//     DM_ARB_RR_EN defined   : round-robin between the two requesters; a
//                              one-bit pointer names the preferred requester
//                              and flips to the other one after every grant.
//     DM_ARB_RR_EN undefined : fixed priority, requester 0 always wins and no
//                              pointer is built.
//
//   Ports
//     Clk, Rst              : clock, asynchronous active-high reset
//     req0/req1             : request, held with stable fields until ack
//     addr0/addr1 [ADDR_W]  : byte address
//     wd0/wd1     [DATA_W]  : write data, byte 0 in bits [7:0]
//     we0/we1               : 1 = write, 0 = read
//     be0/be1     [3:0]     : DM size encoding (byte/half/word)
//     ack0/ack1             : one-cycle completion pulse
//     err0/err1             : access rejected (valid with ack only)
//     rdata       [DATA_W]  : read result, updated at the end of ACC
//     busy                  : FSM not in IDLE
//     dm_A/dm_WD/dm_We/dm_BE: command to the DM
//     dm_RD       [DATA_W]  : combinational read data from the DM
// ---------------------------------------------------------------------------
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        be0,
  input  logic [3:0]        be1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_A,
  output logic [DATA_W-1:0] dm_WD,
  output logic              dm_We,
  output logic [3:0]        dm_BE,
  input  logic [DATA_W-1:0] dm_RD
);

  dm_state_e state_q, state_d;

  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wd_q,   cmd_wd_d;
  logic              cmd_we_q,   cmd_we_d;
  logic [3:0]        cmd_be_q,   cmd_be_d;
  logic              cmd_id_q,   cmd_id_d;
  logic              cmd_err_q,  cmd_err_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;

  logic              any_req;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic              sel_err;
  logic              grant;

  assign any_req = req0 | req1;
  assign grant   = (state_q == ST_IDLE) && any_req;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef DM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // The pointer only matters on a tie; a lone requester always wins.
  assign win = (req0 && req1) ? ptr_q : req1;

  // Flips on every grant, errored or not, so a tie alternates 0,1,0,1.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = ~win;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Requester 1 is served only while the CPU is not asking.
  assign win = ~req0;
`endif

  assign sel_addr = win ? addr1 : addr0;
  assign sel_wd   = win ? wd1   : wd0;
  assign sel_we   = win ? we1   : we0;
  assign sel_be   = win ? be1   : be0;

  dm_align_chk u_align_chk (
    .addr_lo_i (sel_addr[1:0]),
    .be_i      (sel_be),
    .we_i      (sel_we),
    .err_o     (sel_err)
  );

  // -------------------------------------------------------------------------
  // Sequencer next state: IDLE latches the command, ACC captures read data,
  // RSP acknowledges and always returns to IDLE without sampling requests.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cmd_addr_d = cmd_addr_q;
    cmd_wd_d   = cmd_wd_q;
    cmd_we_d   = cmd_we_q;
    cmd_be_d   = cmd_be_q;
    cmd_id_d   = cmd_id_q;
    cmd_err_d  = cmd_err_q;
    rdata_d    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          cmd_addr_d = sel_addr;
          cmd_wd_d   = sel_wd;
          cmd_we_d   = sel_we;
          cmd_be_d   = sel_be;
          cmd_id_d   = win;
          cmd_err_d  = sel_err;
          state_d    = ST_ACC;
        end
      end
      ST_ACC: begin
        // A rejected read leaves the previous result on rdata.
        if (!cmd_we_q && !cmd_err_q) begin
          rdata_d = dm_RD;
        end
        state_d = ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      cmd_addr_q <= '0;
      cmd_wd_q   <= '0;
      cmd_we_q   <= 1'b0;
      cmd_be_q   <= '0;
      cmd_id_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wd_q   <= cmd_wd_d;
      cmd_we_q   <= cmd_we_d;
      cmd_be_q   <= cmd_be_d;
      cmd_id_q   <= cmd_id_d;
      cmd_err_q  <= cmd_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only. Because the write strobe is
  // a decode of state_q, an asynchronous reset during ACC removes it before
  // the committing edge.
  // -------------------------------------------------------------------------
  assign dm_A  = cmd_addr_q;
  assign dm_WD = cmd_wd_q;
  assign dm_We = (state_q == ST_ACC) && cmd_we_q && !cmd_err_q;
  assign dm_BE = (state_q == ST_ACC) ? cmd_be_q : 4'b0000;

  assign ack0  = (state_q == ST_RSP) && !cmd_id_q;
  assign ack1  = (state_q == ST_RSP) &&  cmd_id_q;
  assign err0  = ack0 && cmd_err_q;
  assign err1  = ack1 && cmd_err_q;
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
`timescale 1ns/1ps
module tb_dm_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic          we0, we1;
  logic [3:0]    be0, be1;
  logic          ack0, ack1, err0, err1, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] dm_A;
  logic [DW-1:0] dm_WD;
  logic          dm_We;
  logic [3:0]    dm_BE;
  logic [DW-1:0] dm_RD;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wd0(wd0), .wd1(wd1),
    .we0(we0), .we1(we1),
    .be0(be0), .be1(be1),
    .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_We(dm_We), .dm_BE(dm_BE),
    .dm_RD(dm_RD)
  );

  // ---------------- data memory environment ----------------
  logic [7:0] mem [0:4095];
  logic       init_mem;
  int         we_pulses = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  assign dm_RD = {mem[dm_A + 12'd3], mem[dm_A + 12'd2], mem[dm_A + 12'd1], mem[dm_A]};

  always @(posedge Clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (dm_We) begin
      we_pulses <= we_pulses + 1;
      case (dm_BE)
        4'b1000: mem[dm_A] <= dm_WD[7:0];
        4'b1100: begin
          mem[dm_A]         <= dm_WD[7:0];
          mem[dm_A + 12'd1] <= dm_WD[15:8];
        end
        4'b1111: begin
          mem[dm_A]         <= dm_WD[7:0];
          mem[dm_A + 12'd1] <= dm_WD[15:8];
          mem[dm_A + 12'd2] <= dm_WD[23:16];
          mem[dm_A + 12'd3] <= dm_WD[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] ref_rdata = 32'h0;
  int          ref_ptr   = 0;

  function automatic bit ref_err(input int a, input bit w, input logic [3:0] b);
    bit legal;
    legal = (b == 4'd8) || (b == 4'd12) || (b == 4'd15);
    if (w && !legal) return 1'b1;
    if (b == 4'd12 && (a % 2) != 0) return 1'b1;
    if (b == 4'd15 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[(a + 3) % 4096], ref_mem[(a + 2) % 4096],
            ref_mem[(a + 1) % 4096], ref_mem[a % 4096]};
  endfunction

  task automatic ref_write(input int a, input logic [31:0] d, input logic [3:0] b);
    int n;
    n = (b == 4'd8) ? 1 : (b == 4'd12) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[(a + k) % 4096] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  function automatic int exp_tie_winner();
`ifdef DM_ARB_RR_EN
    return ref_ptr;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access from a single requester, starting from an idle arbiter.
  task automatic access(input int id, input int a, input logic [31:0] d,
                        input bit w, input logic [3:0] b, input string tag);
    int cyc;
    bit got;
    bit e;
    int p0;
    e   = ref_err(a, w, b);
    p0  = we_pulses;
    @(negedge Clk);
    if (id == 0) begin
      addr0 = 12'(a); wd0 = d; we0 = w; be0 = b; req0 = 1'b1;
    end else begin
      addr1 = 12'(a); wd1 = d; we1 = w; be1 = b; req1 = 1'b1;
    end
    got = 0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_acc_A"},  32'(dm_A), 32'(a));
        check({tag, "_acc_BE"}, 32'(dm_BE), 32'(b));
        check({tag, "_acc_We"}, 32'(dm_We), 32'(w && !e));
      end
      if ((id == 0) ? ack0 : ack1) got = 1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(cyc), 32'd2);
      check({tag, "_err"}, 32'((id == 0) ? err0 : err1), 32'(e));
      check({tag, "_other_ack"}, 32'((id == 0) ? ack1 : ack0), 32'd0);
      if (!w && !e) ref_rdata = ref_word(a);
      check({tag, "_rdata"}, rdata, ref_rdata);
    end
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    if (w && !e) ref_write(a, d, b);
    ref_ptr = 1 - id;
    check({tag, "_we_pulses"}, 32'(we_pulses - p0), 32'((w && !e) ? 1 : 0));
    @(negedge Clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // Both requesters read continuously; after n grants requester 0 drops and
  // one more grant is expected for requester 1.
  task automatic both_held(input int n, input string tag);
    int cyc;
    bit seen;
    int exp_id;
    int got_id;
    @(negedge Clk);
    addr0 = 12'h200; we0 = 1'b0; be0 = 4'hF;
    addr1 = 12'h204; we1 = 1'b0; be1 = 4'hF;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k <= n; k++) begin
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 20) begin
        @(negedge Clk);
        cyc++;
        if (ack0 || ack1) seen = 1;
      end
      check($sformatf("%s_g%0d_seen", tag, k), 32'(seen), 32'd1);
      exp_id = (k == n) ? 1 : exp_tie_winner();
      got_id = ack1 ? 1 : 0;
      check($sformatf("%s_g%0d_id", tag, k), 32'(got_id), 32'(exp_id));
      check($sformatf("%s_g%0d_dual", tag, k), 32'(ack0 && ack1), 32'd0);
      ref_ptr   = 1 - exp_id;
      ref_rdata = ref_word((exp_id == 1) ? 12'h204 : 12'h200);
      check($sformatf("%s_g%0d_rdata", tag, k), rdata, ref_rdata);
      if (k == n - 1) req0 = 1'b0;
    end
    req1 = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int          id, a, sel;
    bit          w, seen;
    logic [31:0] d;
    logic [3:0]  b;
    logic [3:0]  be_tab [5];
    logic [31:0] word;

    be_tab[0] = 4'b1000; be_tab[1] = 4'b1100; be_tab[2] = 4'b1111;
    be_tab[3] = 4'b0011; be_tab[4] = 4'b0001;

    init_mem = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    we0 = 1'b0; we1 = 1'b0; be0 = '0; be1 = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);

    #1 Rst = 1'b1;
    #1;
    check("rst_ack0",  32'(ack0), 32'd0);
    check("rst_ack1",  32'(ack1), 32'd0);
    check("rst_err0",  32'(err0), 32'd0);
    check("rst_err1",  32'(err1), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_dm_We", 32'(dm_We), 32'd0);
    check("rst_dm_BE", 32'(dm_BE), 32'd0);
    check("rst_dm_A",  32'(dm_A), 32'd0);
    check("rst_dm_WD", dm_WD, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    init_mem = 1'b0;

    // word write then read back
    access(0, 12'h010, 32'hA1B2C3D4, 1'b1, 4'b1111, "wr010");
    access(0, 12'h010, 32'h0, 1'b0, 4'b1111, "rd010");
    check("rd010_value", rdata, 32'hA1B2C3D4);

    // misaligned halfword write rejected
    access(1, 12'h021, 32'h5A5A5A5A, 1'b1, 4'b1100, "wr021");
    access(1, 12'h020, 32'h0, 1'b0, 4'b1111, "rd020");

    // both held together
    both_held(4, "tie");

    // byte write into lane 3
    access(0, 12'h033, 32'h000000EE, 1'b1, 4'b1000, "wr033");
    access(0, 12'h030, 32'h0, 1'b0, 4'b1111, "rd030");
    word = rdata;
    check("rd030_b3", 32'(word[31:24]), 32'hEE);
    check("rd030_low", 32'(word[23:0]),
          32'({pat(12'h032), pat(12'h031), pat(12'h030)}));

    // reset in the middle of a write's ACC cycle
    @(negedge Clk);
    addr0 = 12'h040; wd0 = 32'hDEADBEEF; we0 = 1'b1; be0 = 4'hF; req0 = 1'b1;
    @(negedge Clk);
    check("rstacc_We_before", 32'(dm_We), 32'd1);
    #1 Rst = 1'b1;
    req0 = 1'b0;
    #1;
    check("rstacc_We_after", 32'(dm_We), 32'd0);
    check("rstacc_busy", 32'(busy), 32'd0);
    ref_ptr = 0;
    ref_rdata = 32'h0;
    @(negedge Clk);
    Rst = 1'b0;
    check("rstacc_rdata", rdata, 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge Clk);
      if (ack0 || ack1) seen = 1;
    end
    check("rstacc_no_ack", 32'(seen), 32'd0);
    both_held(1, "postrst");
    access(0, 12'h040, 32'h0, 1'b0, 4'b1111, "rd040");

    // illegal byte-enable write
    access(0, 12'h050, 32'h12345678, 1'b1, 4'b0011, "wr050");
    access(1, 12'h050, 32'h0, 1'b0, 4'b1111, "rd050");

    // randomized single-requester traffic
    for (int i = 0; i < 40; i++) begin
      id  = int'($urandom_range(0, 1));
      a   = 12'h100 + int'($urandom_range(0, 63));
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, w ? 4 : 2));
      b   = be_tab[sel];
      d   = $urandom;
      access(id, a, d, w, b, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      access(int'($urandom_range(0, 1)), 12'h100 + 4 * i, 32'h0, 1'b0, 4'b1111,
             $sformatf("scan%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
